// File: rtl/uvmt_sb_st_rst_seq_pkg.sv
// Shared types and defaults for the bench reset sequencer.
package uvmt_sb_st_rst_seq_pkg;

  typedef enum logic [2:0] {
    POR    = 3'd0,
    IDLE   = 3'd1,
    ASSERT = 3'd2,
    SETTLE = 3'd3,
    ACK    = 3'd4
  } rst_seq_state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_STAT_W  = 16;

  // Round-robin pointer advance: one past the winner, wrapping at n.
  function automatic int rr_next(input int win, input int n);
    return (win + 1 >= n) ? 0 : win + 1;
  endfunction

endpackage

// File: rtl/uvmt_sb_st_rst_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module uvmt_sb_st_rst_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic               valid_o,
  output logic [IDW-1:0]     winner_o
);

  logic [IDW-1:0] idx;

  // Scan from the far end so the lowest offset from ptr_i is assigned last and wins.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr_i) + i) % NUM_REQ);
      if (req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/uvmt_sb_st_rst_seq_ctrl.sv
// Bench reset sequencer: power-on reset, then round-robin served reset requests.
// Optional completed-sequence counter enabled by UVMT_SB_ST_RST_SEQ_STATS_EN.
module uvmt_sb_st_rst_seq_ctrl
  import uvmt_sb_st_rst_seq_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int STAT_W  = DEF_STAT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         ack,
  input  logic [CNT_W-1:0]           hold_cycles,
  input  logic [CNT_W-1:0]           settle_cycles,
  output logic                       rst_out,
  output logic                       rst_n_out,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output rst_seq_state_t             dbg_state
`ifdef UVMT_SB_ST_RST_SEQ_STATS_EN
  ,
  output logic [STAT_W-1:0]          rst_count
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  // Handshake: req[i] is a level held by requester i until ack[i] pulses for one
  // cycle; there is no ready path and an unserved, dropped req is simply forgotten.

  rst_seq_state_t     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   settle_q, settle_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic               rst_q, rst_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               por_ld_q, por_ld_d;

  logic               arb_valid;
  logic [IDW-1:0]     arb_win;
  logic [CNT_W-1:0]   hold_eff;

  assign hold_eff = (hold_cycles == '0) ? CNT_W'(1) : hold_cycles;

  uvmt_sb_st_rst_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .valid_o  (arb_valid),
    .winner_o (arb_win)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    rst_d    = rst_q;
    ack_d    = '0;
    por_ld_d = por_ld_q;
    case (state_q)
      POR: begin
        // First clock after reset release samples the POR hold length.
        if (!por_ld_q) begin
          por_ld_d = 1'b1;
          cnt_d    = hold_eff;
          rst_d    = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          rst_d = 1'b1;
        end else begin
          rst_d   = 1'b0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (arb_valid) begin
          state_d  = ASSERT;
          grant_d  = arb_win;
          cnt_d    = hold_eff;
          settle_d = settle_cycles;
          rr_ptr_d = IDW'(rr_next(int'(arb_win), NUM_REQ));
        end
      end
      ASSERT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          rst_d = 1'b1;
        end else begin
          rst_d = 1'b0;
          if (settle_q == '0) begin
            state_d        = ACK;
            ack_d[grant_q] = 1'b1;
          end else begin
            state_d = SETTLE;
            cnt_d   = settle_q - CNT_W'(1);
          end
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d        = ACK;
          ack_d[grant_q] = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= POR;
      cnt_q    <= '0;
      settle_q <= '0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      rst_q    <= 1'b1;
      ack_q    <= '0;
      por_ld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      rst_q    <= rst_d;
      ack_q    <= ack_d;
      por_ld_q <= por_ld_d;
    end
  end

  assign rst_out   = rst_q;
  assign rst_n_out = ~rst_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;
  assign ack       = ack_q;
  assign dbg_state = state_q;

`ifdef UVMT_SB_ST_RST_SEQ_STATS_EN
  logic [STAT_W-1:0] stat_q;

  // Saturating count of acks; only block reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_q <= '0;
    end else if ((|ack_d) && (stat_q != '1)) begin
      stat_q <= stat_q + STAT_W'(1);
    end
  end

  assign rst_count = stat_q;
`else
  logic unused_stat_w;
  assign unused_stat_w = (STAT_W > 0);
`endif

endmodule
